// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and default widths for the elastic pipeline stage.
// Optional performance counters are enabled with PIPE_STAGE_PERF_EN.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 100;
  localparam int CNT_W_DEF  = 32;

  // Encoding doubles as the live-entry count driven on occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // ID/EX control bundle; users pack it (zero-extended) into the ctrl field.
  typedef struct packed {
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [2:0] alu_control;
    logic       branch;
    logic       alu_src;
    logic [1:0] flag_write;
    logic [3:0] cond;
  } idex_ctrl_t;

  // Zero-extend an ID/EX bundle to the default control width.
  function automatic logic [CTRL_W_DEF-1:0] pack_idex_ctrl(input idex_ctrl_t c);
    return CTRL_W_DEF'(c);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready bundle carrying a control word and a data word.
// master drives valid/ctrl/data, slave drives ready.
interface pipe_stage_skid_if #(
  parameter int CTRL_W = pipe_pkg::CTRL_W_DEF,
  parameter int DATA_W = pipe_pkg::DATA_W_DEF
) ();

  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input  ready);
  modport slave  (input  valid, input  ctrl, input  data, output ready);

endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter used for the optional stage performance counters.
module pipe_sat_counter #(
  parameter int CNT_W = pipe_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q;

  // Count up on inc_i and stick at all-ones.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + ONE_C;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_PERF_EN to add stall/bubble/flush saturating counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
`ifdef PIPE_STAGE_PERF_EN
  ,
  parameter int CNT_W  = CNT_W_DEF
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  pipe_stage_skid_if.slave   up_if,
  pipe_stage_skid_if.master  dn_if,
  output logic [1:0]         occupancy_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]   stall_cnt_o,
  output logic [CNT_W-1:0]   bubble_cnt_o,
  output logic [CNT_W-1:0]   flush_cnt_o
`endif
);

  state_e            state_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              in_ready_q;

  logic out_valid;
  logic accept;
  logic emit;

  assign out_valid = (state_q != EMPTY);
  assign accept    = up_if.valid & in_ready_q;
  assign emit      = out_valid & dn_if.ready;

  // NOTE: in_ready is a register of "skid not full", so out_ready never reaches it combinationally.
  assign up_if.ready = in_ready_q;
  assign dn_if.valid = out_valid;
  assign dn_if.ctrl  = main_ctrl_q;
  assign dn_if.data  = main_data_q;
  assign occupancy_o = state_q;

  // Main/skid FSM: FIFO order, flush squashes control and empties the stage.
  // NOTE: data registers are reset as well because out_data must read zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
    end else if (flush_i) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      skid_ctrl_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            main_ctrl_q <= up_if.ctrl;
            main_data_q <= up_if.data;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (emit && accept) begin
            main_ctrl_q <= up_if.ctrl;
            main_data_q <= up_if.data;
          end else if (emit) begin
            main_ctrl_q <= '0;
            state_q     <= EMPTY;
          end else if (accept) begin
            skid_ctrl_q <= up_if.ctrl;
            skid_data_q <= up_if.data;
            in_ready_q  <= 1'b0;
            state_q     <= FULL;
          end
        end
        FULL: begin
          if (emit) begin
            main_ctrl_q <= skid_ctrl_q;
            main_data_q <= skid_data_q;
            skid_ctrl_q <= '0;
            in_ready_q  <= 1'b1;
            state_q     <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          main_ctrl_q <= '0;
          skid_ctrl_q <= '0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (out_valid & ~dn_if.ready),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~out_valid),
    .cnt_o (bubble_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (flush_i),
    .cnt_o (flush_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: queue-based reference model with a
// per-cycle compare, directed scenarios with literal expectations, and a
// randomised run. Counter checks are added when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int CW = 16;
  localparam int DW = 100;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [1:0] occ;
  logic check_en = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) up ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) dn ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .up_if       (up),
    .dn_if       (dn),
    .occupancy_o (occ)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt_o (stall_cnt),
    .bubble_cnt_o(bubble_cnt),
    .flush_cnt_o (flush_cnt)
`endif
  );

  // Standalone narrow counter so saturation is reachable in a few cycles.
  logic       sc_rst = 1'b1;
  logic       sc_inc = 1'b0;
  logic [2:0] sc_cnt;

  pipe_sat_counter #(.CNT_W(3)) u_sc (
    .clk   (clk),
    .rst   (sc_rst),
    .inc_i (sc_inc),
    .cnt_o (sc_cnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: a FIFO of at most two entries ----------
  typedef struct {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] shown_d = '0;
  int            m_stall = 0;
  int            m_bubble = 0;
  int            m_flush = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      shown_d  <= '0;
      m_stall  <= 0;
      m_bubble <= 0;
      m_flush  <= 0;
    end else begin
      if (q.size() > 0 && !dn.ready) m_stall <= m_stall + 1;
      if (q.size() == 0) m_bubble <= m_bubble + 1;
      if (flush) m_flush <= m_flush + 1;
      if (flush) begin
        q.delete();
      end else if (up.valid && q.size() < 2) begin
        if (q.size() > 0 && dn.ready) void'(q.pop_front());
        q.push_back('{up.ctrl, up.data});
      end else if (q.size() > 0 && dn.ready) begin
        void'(q.pop_front());
      end
      if (q.size() > 0) shown_d <= q[0].d;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en && !rst) begin
      check("out_valid", 128'(dn.valid), 128'(q.size() > 0));
      check("in_ready",  128'(up.ready), 128'(q.size() < 2));
      check("occupancy", 128'(occ),      128'(q.size()));
      check("out_ctrl",  128'(dn.ctrl),  (q.size() > 0) ? 128'(q[0].c) : 128'(0));
      check("out_data",  128'(dn.data),  128'(shown_d));
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt",  128'(stall_cnt),  128'(m_stall));
      check("bubble_cnt", 128'(bubble_cnt), 128'(m_bubble));
      check("flush_cnt",  128'(flush_cnt),  128'(m_flush));
`endif
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [CW-1:0] mk_ctrl(input logic [DW-1:0] d);
    return {8'h01, d[7:0]};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    up.valid = v;
    up.data  = d;
    up.ctrl  = mk_ctrl(d);
    dn.ready = r;
    flush    = f;
  endtask

  logic [127:0] rnd;

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(dn.valid), 128'(0));
    check("rst_in_ready",  128'(up.ready), 128'(1));
    check("rst_occ",       128'(occ),      128'(0));
    check("rst_out_data",  128'(dn.data),  128'(0));
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);

    // Streaming: one entry per cycle, latency one cycle, occupancy stays at 1.
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0);
      @(negedge clk);
      check("stream_data", 128'(dn.data), 128'(i));
      check("stream_occ",  128'(occ),     128'(1));
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("stream_drain_occ", 128'(occ), 128'(0));

    // Backpressure: 0x11 held, 0x22 skidded, 0x33 refused until space frees.
    drive(1'b1, DW'(8'h11), 1'b0, 1'b0);
    @(negedge clk);
    check("bp_out_11", 128'(dn.data), 128'(8'h11));
    drive(1'b1, DW'(8'h22), 1'b0, 1'b0);
    @(negedge clk);
    check("bp_occ_full",  128'(occ),      128'(2));
    check("bp_ready_low", 128'(up.ready), 128'(0));
    drive(1'b1, DW'(8'h33), 1'b0, 1'b0);
    @(negedge clk);
    check("bp_hold_11",   128'(dn.data), 128'(8'h11));
    check("bp_hold_ctrl", 128'(dn.ctrl), 128'(16'h0111));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_out_22", 128'(dn.data), 128'(8'h22));
    drive(1'b1, DW'(8'h33), 1'b1, 1'b0);
    @(negedge clk);
    check("bp_out_33", 128'(dn.data), 128'(8'h33));
    drive(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    check("bp_empty", 128'(dn.valid), 128'(0));

    // Flush collision: stage full, flush wins over accept and emit.
    drive(1'b1, DW'(8'h55), 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, DW'(8'h66), 1'b0, 1'b0);
    @(negedge clk);
    check("fl_pre_occ", 128'(occ), 128'(2));
    drive(1'b1, DW'(8'h44), 1'b1, 1'b1);
    @(negedge clk);
    check("fl_valid",    128'(dn.valid), 128'(0));
    check("fl_ctrl",     128'(dn.ctrl),  128'(0));
    check("fl_occ",      128'(occ),      128'(0));
    check("fl_in_ready", 128'(up.ready), 128'(1));
    check("fl_data_hold", 128'(dn.data), 128'(8'h55));
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("fl_no_44", 128'(dn.valid), 128'(0));
    end

    // Reset mid-operation from FULL.
    drive(1'b1, DW'(8'hA1), 1'b0, 1'b0);
    up.ctrl = 16'h00AB;
    @(negedge clk);
    drive(1'b1, DW'(8'hA2), 1'b0, 1'b0);
    up.ctrl = 16'h00CD;
    @(negedge clk);
    check("mr_pre_occ",  128'(occ),     128'(2));
    check("mr_pre_ctrl", 128'(dn.ctrl), 128'(16'h00AB));
    drive(1'b0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("mr_valid",    128'(dn.valid), 128'(0));
    check("mr_ctrl",     128'(dn.ctrl),  128'(0));
    check("mr_data",     128'(dn.data),  128'(0));
    check("mr_occ",      128'(occ),      128'(0));
    check("mr_in_ready", 128'(up.ready), 128'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Saturating counter: 5 increments -> 5, then sticks at 7.
    sc_rst = 1'b0;
    sc_inc = 1'b1;
    repeat (5) @(negedge clk);
    check("sat_count5", 128'(sc_cnt), 128'(5));
    repeat (5) @(negedge clk);
    check("sat_stick", 128'(sc_cnt), 128'(7));
    sc_inc = 1'b0;
    @(negedge clk);
    check("sat_hold", 128'(sc_cnt), 128'(7));

    // Randomised traffic; the compare process checks every cycle.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      drive(($urandom % 4) != 0, rnd[DW-1:0], ($urandom % 3) != 0, ($urandom % 40) == 0);
      @(negedge clk);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("final_empty", 128'(occ), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
